u_sbd: RTL and testbench

Register scoreboard and issue-stall controller for the execute pipeline. It tracks which integer registers have a write still in flight and stalls issue into the execute stage on RAW/WAW hazards. Fixed-latency ALU-class results (LUI/AUIPC/ALU/ALUi/JAL/JALR) reach the register file a constant LAT cycles after issue. Loads complete on a variable-latency LSU return. It sits between decode and the execute input register.

---
 rtl/pkg_core.sv | 16 +
 rtl/u_sbd_if.sv | 34 +++
 rtl/u_sbd_pipe.sv | 30 +++
 rtl/u_sbd.sv | 110 +++++++++++
 tb/tb_u_sbd.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pkg_core.sv
// Shared core definitions: register-file geometry, scoreboard shadow slot and
// long-op tracker state.
package pkg_core;
  localparam int NREG = 32;
  localparam int REGW = 5;

  typedef struct packed {
    logic            we;
    logic [REGW-1:0] a;
  } sb_slot_t;

  typedef enum logic {
    L_IDLE = 1'b0,
    L_BUSY = 1'b1
  } long_st_e;
endpackage

// File: rtl/u_sbd_if.sv
// Decode <-> scoreboard handshake bundle: issue request, LSU completion, flush
// and the scoreboard's stall/status outputs.
interface u_sbd_if #(
  parameter int CNTW = 32
);
  import pkg_core::*;

  logic            iss_valid;
  logic [REGW-1:0] iss_rs1_a;
  logic            iss_rs1_use;
  logic [REGW-1:0] iss_rs2_a;
  logic            iss_rs2_use;
  logic [REGW-1:0] iss_rd_a;
  logic            iss_rd_we;
  logic            iss_long;
  logic            lsu_done;
  logic            flush;
  logic            iss_stall;
  logic [NREG-1:0] busy;
  logic            long_pend;
  logic [CNTW-1:0] stall_cnt;

  modport master (
    output iss_valid, iss_rs1_a, iss_rs1_use, iss_rs2_a, iss_rs2_use,
           iss_rd_a, iss_rd_we, iss_long, lsu_done, flush,
    input  iss_stall, busy, long_pend, stall_cnt
  );

  modport slave (
    input  iss_valid, iss_rs1_a, iss_rs1_use, iss_rs2_a, iss_rs2_use,
           iss_rd_a, iss_rd_we, iss_long, lsu_done, flush,
    output iss_stall, busy, long_pend, stall_cnt
  );
endinterface

// File: rtl/u_sbd_pipe.sv
// Shadow of the fixed-latency writeback path: a LAT-deep shift register of
// {we, rd} whose last slot marks the register-file write cycle.
module u_sbd_pipe
  import pkg_core::*;
#(
  parameter int LAT = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush_i,
  input  sb_slot_t        slot_i,
  output logic            last_we_o,
  output logic [REGW-1:0] last_a_o
);
  sb_slot_t slot_q [LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) slot_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < LAT; i++) slot_q[i] <= '0;
    end else begin
      slot_q[0] <= slot_i;
      for (int i = 1; i < LAT; i++) slot_q[i] <= slot_q[i-1];
    end
  end

  assign last_we_o = slot_q[LAT-1].we;
  assign last_a_o  = slot_q[LAT-1].a;
endmodule

// File: rtl/u_sbd.sv
// Register scoreboard and issue-stall controller: tracks in-flight integer
// register writes and holds decode on RAW/WAW and long-op structural hazards.
module u_sbd
  import pkg_core::*;
#(
  parameter int LAT  = 4,
  parameter int CNTW = 32
) (
  input logic    clk,
  input logic    rstn,
  u_sbd_if.slave sb
);
  logic [NREG-1:0] busy_q, busy_d;
  logic [REGW-1:0] long_rd_q, long_rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  long_st_e        st_q, st_d;

  logic            haz_rs1, haz_rs2, haz_waw, haz_long;
  logic            stall, accept, rd_nz;
  logic            long_pend, long_clr;
  logic            last_we;
  logic [REGW-1:0] last_a;
  logic [NREG-1:0] set_vec, clr_vec;
  sb_slot_t        slot_in;

  // x0 never reaches busy_q, so the source checks need no explicit x0 guard
  assign rd_nz    = |sb.iss_rd_a;
  assign haz_rs1  = sb.iss_rs1_use & busy_q[sb.iss_rs1_a];
  assign haz_rs2  = sb.iss_rs2_use & busy_q[sb.iss_rs2_a];
  assign haz_waw  = sb.iss_rd_we & rd_nz & busy_q[sb.iss_rd_a];
  assign haz_long = sb.iss_long & long_pend;
  assign stall    = sb.iss_valid & (haz_rs1 | haz_rs2 | haz_waw | haz_long | sb.flush);
  assign accept   = sb.iss_valid & ~stall;

  assign slot_in.we = accept & sb.iss_rd_we & ~sb.iss_long & rd_nz;
  assign slot_in.a  = sb.iss_rd_a;

  u_sbd_pipe #(.LAT(LAT)) u_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .flush_i  (sb.flush),
    .slot_i   (slot_in),
    .last_we_o(last_we),
    .last_a_o (last_a)
  );

  // Long-op tracker: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q      <= L_IDLE;
      long_rd_q <= '0;
    end else begin
      st_q      <= st_d;
      long_rd_q <= long_rd_d;
    end
  end

  // Long-op tracker: next state
  always_comb begin
    st_d      = st_q;
    long_rd_d = long_rd_q;
    unique case (st_q)
      L_IDLE: if (accept & sb.iss_long) begin
        st_d      = L_BUSY;
        long_rd_d = sb.iss_rd_a;
      end
      L_BUSY: if (sb.lsu_done) st_d = L_IDLE;
      default: st_d = L_IDLE;
    endcase
    if (sb.flush) st_d = L_IDLE;
  end

  // Long-op tracker: outputs
  always_comb begin
    long_pend = 1'b0;
    long_clr  = 1'b0;
    if (st_q == L_BUSY) begin
      long_pend = 1'b1;
      long_clr  = sb.lsu_done;
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept & sb.iss_rd_we & rd_nz) set_vec[sb.iss_rd_a] = 1'b1;
    if (last_we)                       clr_vec[last_a]      = 1'b1;
    if (long_clr)                      clr_vec[long_rd_q]   = 1'b1;
    // Set is applied after clear so a same-edge set/clear leaves the bit busy
    busy_d    = sb.flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
    busy_d[0] = 1'b0;
    cnt_d     = cnt_q;
    if (sb.iss_valid & stall & ~(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sb.iss_stall = stall;
  assign sb.busy      = busy_q;
  assign sb.long_pend = long_pend;
  assign sb.stall_cnt = cnt_q;
endmodule

// File: tb/tb_u_sbd.sv
// Bench for u_sbd: directed vector table, saturation/reset sequences and a
// randomized stream checked against a queue-based scoreboard model.
module tb_u_sbd;
  import pkg_core::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  u_sbd_if #(.CNTW(32)) sb ();
  u_sbd_if #(.CNTW(4))  sb4 ();

  u_sbd #(.LAT(LAT), .CNTW(32)) dut  (.clk(clk), .rstn(rstn), .sb(sb));
  u_sbd #(.LAT(LAT), .CNTW(4))  dut4 (.clk(clk), .rstn(rstn), .sb(sb4));

  always_comb begin
    sb4.iss_valid   = sb.iss_valid;
    sb4.iss_rs1_a   = sb.iss_rs1_a;
    sb4.iss_rs1_use = sb.iss_rs1_use;
    sb4.iss_rs2_a   = sb.iss_rs2_a;
    sb4.iss_rs2_use = sb.iss_rs2_use;
    sb4.iss_rd_a    = sb.iss_rd_a;
    sb4.iss_rd_we   = sb.iss_rd_we;
    sb4.iss_long    = sb.iss_long;
    sb4.lsu_done    = sb.lsu_done;
    sb4.flush       = sb.flush;
  end

  typedef struct {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic we; logic lng; logic lsu; logic fl;
  } in_t;

  typedef struct {
    in_t         i;
    logic        e_stall;
    logic [31:0] e_busy;
    logic        e_lp;
    int          e_cnt;
  } vec_t;

  typedef struct { int due; logic [4:0] a; } pend_t;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] m_busy;
  logic        m_lp;
  logic [4:0]  m_lrd;
  int          m_cnt;
  int          cyc;
  pend_t       pend[$];
  vec_t        tab[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
  endtask

  function automatic in_t mk(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                             logic [4:0] rd, logic we, logic lng, logic lsu, logic fl);
    in_t r;
    r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.rd = rd; r.we = we; r.lng = lng; r.lsu = lsu; r.fl = fl;
    return r;
  endfunction

  function automatic vec_t mv(in_t i, logic st, logic [31:0] b, logic lp, int c);
    vec_t r;
    r.i = i; r.e_stall = st; r.e_busy = b; r.e_lp = lp; r.e_cnt = c;
    return r;
  endfunction

  function automatic logic m_stall(in_t x);
    return x.v & ((x.u1 & m_busy[x.rs1]) | (x.u2 & m_busy[x.rs2]) |
                  (x.we & (x.rd != 0) & m_busy[x.rd]) | (x.lng & m_lp) | x.fl);
  endfunction

  function automatic int sat15(int c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic model_reset();
    m_busy = '0; m_lp = 1'b0; m_lrd = '0; m_cnt = 0; cyc = 0;
    pend.delete();
  endtask

  // Advance the model across the clock edge that ends the current cycle
  task automatic model_step(input in_t x);
    logic        st, acc;
    logic [31:0] nb;
    st  = m_stall(x);
    acc = x.v & ~st;
    if (x.v & st) m_cnt++;
    if (x.fl) begin
      m_busy = '0; m_lp = 1'b0;
      pend.delete();
    end else begin
      nb = m_busy;
      while (pend.size() > 0 && pend[0].due <= cyc) begin
        nb[pend[0].a] = 1'b0;
        void'(pend.pop_front());
      end
      if (m_lp && x.lsu) begin
        nb[m_lrd] = 1'b0;
        m_lp = 1'b0;
      end
      if (acc && x.we && x.rd != 0) begin
        nb[x.rd] = 1'b1;
        if (!x.lng) pend.push_back('{due: cyc + LAT, a: x.rd});
      end
      if (acc && x.lng) begin
        m_lp = 1'b1;
        m_lrd = x.rd;
      end
      m_busy = nb;
    end
    cyc++;
  endtask

  task automatic apply(input in_t x);
    sb.iss_valid = x.v;  sb.iss_rs1_a = x.rs1; sb.iss_rs1_use = x.u1;
    sb.iss_rs2_a = x.rs2; sb.iss_rs2_use = x.u2; sb.iss_rd_a = x.rd;
    sb.iss_rd_we = x.we; sb.iss_long = x.lng; sb.lsu_done = x.lsu; sb.flush = x.fl;
  endtask

  task automatic drive(input in_t x);
    @(negedge clk);
    apply(x);
    #1;
  endtask

  task automatic check_model(input in_t x);
    chk("stall", 64'(sb.iss_stall), 64'(m_stall(x)));
    chk("busy", 64'(sb.busy), 64'(m_busy));
    chk("long_pend", 64'(sb.long_pend), 64'(m_lp));
    chk("stall_cnt", 64'(sb.stall_cnt), 64'(m_cnt));
    chk("stall_cnt4", 64'(sb4.stall_cnt), 64'(sat15(m_cnt)));
  endtask

  initial begin
    in_t NOP, x;
    NOP = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    // Directed table: alu(rd) = mk(1,..,rd,1,0,..), ld(rd) = long load
    tab.push_back(mv(mk(1,0,0,0,0,1,1,0,0,0), 0, 32'h0, 0, 0));
    tab.push_back(mv(mk(1,0,0,0,0,2,1,0,0,0), 0, 32'h2, 0, 0));
    tab.push_back(mv(mk(1,0,0,0,0,3,1,0,0,0), 0, 32'h6, 0, 0));
    tab.push_back(mv(NOP, 0, 32'hE, 0, 0));
    tab.push_back(mv(NOP, 0, 32'hE, 0, 0));
    tab.push_back(mv(NOP, 0, 32'hC, 0, 0));
    tab.push_back(mv(NOP, 0, 32'h8, 0, 0));
    tab.push_back(mv(NOP, 0, 32'h0, 0, 0));
    tab.push_back(mv(mk(1,0,0,0,0,5,1,0,0,0), 0, 32'h0, 0, 0));
    for (int k = 0; k < 4; k++)
      tab.push_back(mv(mk(1,5,1,0,1,6,1,0,0,0), 1, 32'h20, 0, k));
    tab.push_back(mv(mk(1,5,1,0,1,6,1,0,0,0), 0, 32'h0, 0, 4));
    tab.push_back(mv(NOP, 0, 32'h40, 0, 4));
    tab.push_back(mv(mk(1,0,1,0,0,0,1,0,0,0), 0, 32'h40, 0, 4));
    tab.push_back(mv(mk(1,0,1,0,1,10,1,0,0,0), 0, 32'h40, 0, 4));
    tab.push_back(mv(NOP, 0, 32'h440, 0, 4));
    for (int k = 0; k < 3; k++) tab.push_back(mv(NOP, 0, 32'h400, 0, 4));
    tab.push_back(mv(mk(1,0,1,0,0,7,1,1,0,0), 0, 32'h0, 0, 4));
    for (int k = 0; k < 6; k++)
      tab.push_back(mv(mk(1,0,1,0,0,8,1,1,0,0), 1, 32'h80, 1, 4 + k));
    tab.push_back(mv(mk(1,0,1,0,0,8,1,1,1,0), 1, 32'h80, 1, 10));
    tab.push_back(mv(mk(1,0,1,0,0,8,1,1,0,0), 0, 32'h0, 0, 11));
    tab.push_back(mv(mk(1,7,1,0,0,11,1,0,1,0), 0, 32'h100, 1, 11));
    for (int k = 0; k < 4; k++) tab.push_back(mv(NOP, 0, 32'h800, 0, 11));
    tab.push_back(mv(mk(1,0,0,0,0,9,1,0,0,0), 0, 32'h0, 0, 11));
    tab.push_back(mv(mk(1,0,0,0,0,9,1,1,0,0), 1, 32'h200, 0, 11));
    tab.push_back(mv(mk(1,0,0,0,0,9,1,1,0,1), 1, 32'h200, 0, 12));
    tab.push_back(mv(mk(1,0,0,0,0,9,1,1,0,0), 0, 32'h0, 0, 13));
    tab.push_back(mv(NOP, 0, 32'h200, 1, 13));
    tab.push_back(mv(mk(0,0,0,0,0,0,0,0,0,1), 0, 32'h200, 1, 13));
    tab.push_back(mv(NOP, 0, 32'h0, 0, 13));
    tab.push_back(mv(mk(0,0,0,0,0,0,0,0,1,0), 0, 32'h0, 0, 13));
    tab.push_back(mv(NOP, 0, 32'h0, 0, 13));

    // Reset state
    rstn = 1'b0;
    apply(mk(1,1,1,2,1,3,1,1,0,0));
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 64'(sb.iss_stall), 64'(0));
    chk("rst_busy", 64'(sb.busy), 64'(0));
    chk("rst_long_pend", 64'(sb.long_pend), 64'(0));
    chk("rst_stall_cnt", 64'(sb.stall_cnt), 64'(0));
    apply(NOP);
    rstn = 1'b1;

    foreach (tab[k]) begin
      drive(tab[k].i);
      chk("tab_stall", 64'(sb.iss_stall), 64'(tab[k].e_stall));
      chk("tab_busy", 64'(sb.busy), 64'(tab[k].e_busy));
      chk("tab_long_pend", 64'(sb.long_pend), 64'(tab[k].e_lp));
      chk("tab_stall_cnt", 64'(sb.stall_cnt), 64'(tab[k].e_cnt));
      chk("tab_stall_cnt4", 64'(sb4.stall_cnt), 64'(sat15(tab[k].e_cnt)));
      model_step(tab[k].i);
    end

    // Saturation: 20 stalled cycles behind an outstanding load
    x = mk(1,0,0,0,0,13,1,1,0,0);
    drive(x); check_model(x); model_step(x);
    x = mk(1,0,0,0,0,14,1,1,0,0);
    for (int k = 0; k < 20; k++) begin
      drive(x); check_model(x); model_step(x);
    end
    x = mk(0,0,0,0,0,0,0,0,1,0);
    drive(x);
    chk("sat_cnt4", 64'(sb4.stall_cnt), 64'(15));
    chk("sat_cnt32", 64'(sb.stall_cnt), 64'(33));
    model_step(x);

    // Randomized stream against the model
    for (int k = 0; k < 2000; k++) begin
      x.v   = ($urandom % 10) < 7;
      x.rs1 = 5'($urandom_range(0, 7)); x.u1 = 1'($urandom);
      x.rs2 = 5'($urandom_range(0, 7)); x.u2 = 1'($urandom);
      x.rd  = 5'($urandom_range(0, 7)); x.we = ($urandom % 4) != 0;
      x.lng = ($urandom % 8) == 0;
      x.lsu = ($urandom % 5) == 0;
      x.fl  = ($urandom % 64) == 0;
      drive(x); check_model(x); model_step(x);
    end

    // Asynchronous reset with writes in flight
    x = mk(0,0,0,0,0,0,0,0,0,1);
    drive(x); check_model(x); model_step(x);
    x = mk(1,0,0,0,0,14,1,0,0,0);
    drive(x); check_model(x); model_step(x);
    x = mk(1,0,0,0,0,15,1,1,0,0);
    drive(x); check_model(x); model_step(x);
    drive(NOP); check_model(NOP);
    chk("pre_rst_busy", 64'(sb.busy), 64'(32'hC000));
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(sb.busy), 64'(0));
    chk("mid_rst_long_pend", 64'(sb.long_pend), 64'(0));
    chk("mid_rst_stall_cnt", 64'(sb.stall_cnt), 64'(0));
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    x = mk(1,14,1,15,1,15,1,1,0,0);
    drive(x); check_model(x); model_step(x);
    drive(NOP); check_model(NOP);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
